// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (fetch / data) arbiter in front of a single-port
// asynchronous SRAM. One access runs at a time. The requester is picked in IDLE:
// a lone request wins, and a tie goes to the port that was not granted last.
// Its address, direction and write data are latched at that edge.
//
// Ports
//   clock, clear             clock; synchronous active-high reset
//   f_req, f_addr            fetch port (read only)
//   d_req, d_we, d_addr,     data port (read or write)
//   d_wdata
//   f_done, d_done           one-cycle completion pulse per port
//   rdata                    registered read result (valid with done)
//   err                      out-of-range flag, high with the done pulse
//   busy                     high in every state except IDLE
//   ram_read, ram_write      RAM enables (never both high)
//   ram_addr, ram_dout       RAM address / write data (0 when idle)
//   ram_dout_en              enable for the top-level tri-state data driver
//   ram_din                  RAM data bus as read back
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and operand latch happen here
// RD    | RAM read strobe; rdata captures ram_din on exit
// WS    | write setup: address/data driven, write enable still low
// WR    | write strobe
// WH    | write hold: address/data held after the strobe drops
// DONE  | done pulse for the granted port (plus err if out of range)
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              f_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_dout_en,
    input  logic [DATA_W-1:0] ram_din
);

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WS,
        S_WR,
        S_WH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              last_d;     // 1: data port was granted most recently
    logic              sel_d;      // port owning the current access
    logic              op_we;
    logic              op_oor;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [DATA_W-1:0] rdata_q;

    // Arbitration, only meaningful while in IDLE.
    logic              any_req;
    logic              pick_d;
    logic              pick_we;
    logic              pick_oor;
    logic [ADDR_W-1:0] pick_addr;
    logic              in_write;

    assign any_req   = f_req | d_req;
    assign pick_d    = d_req & (~f_req | ~last_d);
    assign pick_addr = pick_d ? d_addr : f_addr;
    assign pick_we   = pick_d & d_we;
    assign pick_oor  = ({1'b0, pick_addr} >= DEPTH_LIM);

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            last_d   <= 1'b0;
            sel_d    <= 1'b0;
            op_we    <= 1'b0;
            op_oor   <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                sel_d    <= pick_d;
                last_d   <= pick_d;
                op_we    <= pick_we;
                op_oor   <= pick_oor;
                op_addr  <= pick_addr;
                op_wdata <= pick_d ? d_wdata : '0;
                if (pick_oor) begin
                    rdata_q <= '0;
                end
            end
            if (state == S_RD) begin
                rdata_q <= ram_din;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        in_write    = 1'b0;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ram_dout_en = 1'b0;
        ram_addr    = '0;
        ram_dout    = '0;
        f_done      = 1'b0;
        d_done      = 1'b0;
        err         = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (pick_oor) begin
                        state_nxt = S_DONE;
                    end else if (pick_we) begin
                        state_nxt = S_WS;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                ram_read  = 1'b1;
                ram_addr  = op_addr;
                state_nxt = S_DONE;
            end
            S_WS: begin
                in_write  = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                in_write  = 1'b1;
                ram_write = 1'b1;
                state_nxt = S_WH;
            end
            S_WH: begin
                in_write  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                f_done    = ~sel_d;
                d_done    = sel_d;
                err       = op_oor;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (in_write) begin
            ram_dout_en = 1'b1;
            ram_addr    = op_addr;
            ram_dout    = op_wdata;
        end
    end

    assign rdata = rdata_q;

    // op_we is implied by the state path taken; keep it for debug visibility.
    logic unused_ok;
    assign unused_ok = op_we;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        clear;
    logic        f_req;
    logic [8:0]  f_addr;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        f_done, d_done, err, busy;
    logic [31:0] rdata;
    logic        ram_read, ram_write, ram_dout_en;
    logic [8:0]  ram_addr;
    logic [31:0] ram_dout;
    logic [31:0] ram_din;

    int n_cmp  = 0;
    int n_fail = 0;
    int overlap = 0;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .DEPTH(256)) dut (
        .clock       (clock),
        .clear       (clear),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .f_done      (f_done),
        .d_done      (d_done),
        .rdata       (rdata),
        .err         (err),
        .busy        (busy),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_dout_en (ram_dout_en),
        .ram_din     (ram_din)
    );

    always #5 clock = ~clock;

    // Asynchronous SRAM model: reads are combinational; a write commits when
    // the write strobe falls while address/data are still held (WR -> WH).
    // An aborted write (strobe drops together with the driver) never commits.
    logic [31:0] mem [0:511];
    bit          mem_ready = 1'b0;
    bit          wr_pend   = 1'b0;

    assign ram_din = mem[ram_addr];

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[5]    <= 32'hDEADBEEF;
            mem_ready <= 1'b1;
        end else begin
            if (wr_pend && ram_dout_en) mem[ram_addr] <= ram_dout;
            wr_pend <= ram_write;
        end
    end

    always @(negedge clock) begin
        if (ram_read && ram_write) overlap++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b1; f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();

        // Reset state
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_f_done", f_done, 1'b0);
        chk1 ("rst_d_done", d_done, 1'b0);
        chk1 ("rst_err", err, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);
        chk1 ("rst_ram_read", ram_read, 1'b0);
        chk1 ("rst_ram_write", ram_write, 1'b0);
        chk1 ("rst_dout_en", ram_dout_en, 1'b0);
        chk9 ("rst_ram_addr", ram_addr, 9'h0);
        clear = 1'b0;

        // Fetch read of mem[5]
        f_req = 1'b1; f_addr = 9'h005;
        tick();
        f_req = 1'b0; f_addr = 9'h1FF;
        chk1 ("fr_c1_ram_read", ram_read, 1'b1);
        chk9 ("fr_c1_ram_addr", ram_addr, 9'h005);
        chk1 ("fr_c1_busy", busy, 1'b1);
        chk1 ("fr_c1_f_done", f_done, 1'b0);
        tick();
        chk1 ("fr_c2_f_done", f_done, 1'b1);
        chk1 ("fr_c2_d_done", d_done, 1'b0);
        chk32("fr_c2_rdata", rdata, 32'hDEADBEEF);
        chk1 ("fr_c2_ram_read", ram_read, 1'b0);
        chk9 ("fr_c2_ram_addr", ram_addr, 9'h0);
        tick();
        chk1 ("fr_c3_busy", busy, 1'b0);
        chk1 ("fr_c3_f_done", f_done, 1'b0);

        // Data write of 0x12345678 to 0x5A; late input changes must be ignored
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h05A; d_wdata = 32'h12345678;
        tick();
        d_req = 1'b0; d_we = 1'b0; d_addr = 9'h011; d_wdata = 32'hFFFF0000;
        chk1 ("wr_c1_ram_write", ram_write, 1'b0);
        chk1 ("wr_c1_dout_en", ram_dout_en, 1'b1);
        chk9 ("wr_c1_ram_addr", ram_addr, 9'h05A);
        chk32("wr_c1_ram_dout", ram_dout, 32'h12345678);
        tick();
        chk1 ("wr_c2_ram_write", ram_write, 1'b1);
        chk1 ("wr_c2_ram_read", ram_read, 1'b0);
        chk32("wr_c2_ram_dout", ram_dout, 32'h12345678);
        tick();
        chk1 ("wr_c3_ram_write", ram_write, 1'b0);
        chk1 ("wr_c3_dout_en", ram_dout_en, 1'b1);
        chk9 ("wr_c3_ram_addr", ram_addr, 9'h05A);
        chk1 ("wr_c3_d_done", d_done, 1'b0);
        tick();
        chk1 ("wr_c4_d_done", d_done, 1'b1);
        chk1 ("wr_c4_err", err, 1'b0);
        chk32("wr_c4_rdata_kept", rdata, 32'hDEADBEEF);
        chk1 ("wr_c4_dout_en", ram_dout_en, 1'b0);
        tick();

        // Read back 0x5A through the data port
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h05A;
        tick();
        d_req = 1'b0;
        chk1 ("rb_c1_ram_read", ram_read, 1'b1);
        tick();
        chk1 ("rb_c2_d_done", d_done, 1'b1);
        chk32("rb_c2_rdata", rdata, 32'h12345678);
        tick();

        // Tie straight out of reset: data first, then fetch
        clear = 1'b1;
        tick();
        clear = 1'b0;
        f_req = 1'b1; f_addr = 9'h005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h05A;
        tick();
        chk9 ("tie_c1_addr_data", ram_addr, 9'h05A);
        chk1 ("tie_c1_busy", busy, 1'b1);
        tick();
        chk1 ("tie_c2_d_done", d_done, 1'b1);
        chk1 ("tie_c2_f_done", f_done, 1'b0);
        chk32("tie_c2_rdata", rdata, 32'h12345678);
        chk1 ("tie_c2_busy", busy, 1'b1);
        tick();
        chk1 ("tie_c3_busy_idle", busy, 1'b0);
        tick();
        f_req = 1'b0; d_req = 1'b0;
        chk9 ("tie_c4_addr_fetch", ram_addr, 9'h005);
        chk1 ("tie_c4_busy", busy, 1'b1);
        tick();
        chk1 ("tie_c5_f_done", f_done, 1'b1);
        chk1 ("tie_c5_d_done", d_done, 1'b0);
        chk32("tie_c5_rdata", rdata, 32'hDEADBEEF);
        tick();

        // Out-of-range read at 0x100
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h100;
        tick();
        d_req = 1'b0;
        chk1 ("oor_c1_d_done", d_done, 1'b1);
        chk1 ("oor_c1_err", err, 1'b1);
        chk32("oor_c1_rdata", rdata, 32'h0);
        chk1 ("oor_c1_ram_read", ram_read, 1'b0);
        chk1 ("oor_c1_ram_write", ram_write, 1'b0);
        tick();
        chk1 ("oor_c2_err", err, 1'b0);
        chk1 ("oor_c2_busy", busy, 1'b0);

        // Last in-range word 0xFF takes the normal read path
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h0FF;
        tick();
        d_req = 1'b0;
        chk1 ("edge_c1_ram_read", ram_read, 1'b1);
        chk9 ("edge_c1_ram_addr", ram_addr, 9'h0FF);
        tick();
        chk1 ("edge_c2_d_done", d_done, 1'b1);
        chk1 ("edge_c2_err", err, 1'b0);
        tick();

        // Reset during WR aborts the write
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h033; d_wdata = 32'hAAAA5555;
        tick();
        d_req = 1'b0;
        tick();
        chk1 ("rw_c2_ram_write", ram_write, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk1 ("rw_c3_ram_write", ram_write, 1'b0);
        chk1 ("rw_c3_dout_en", ram_dout_en, 1'b0);
        chk9 ("rw_c3_ram_addr", ram_addr, 9'h0);
        chk32("rw_c3_ram_dout", ram_dout, 32'h0);
        chk1 ("rw_c3_busy", busy, 1'b0);
        chk1 ("rw_c3_d_done", d_done, 1'b0);
        chk32("rw_c3_rdata", rdata, 32'h0);
        tick();
        chk1 ("rw_c4_d_done", d_done, 1'b0);
        chk1 ("rw_c4_busy", busy, 1'b0);
        tick();
        f_req = 1'b1; f_addr = 9'h033;
        tick();
        f_req = 1'b0;
        tick();
        chk1 ("rw_rb_f_done", f_done, 1'b1);
        chk32("rw_rb_rdata", rdata, 32'h0);
        chk32("rw_mem_word", mem[9'h033], 32'h0);
        tick();

        // Back-to-back: fetch held high, data requests once
        f_req = 1'b1; f_addr = 9'h005;
        tick();
        chk9 ("bb_g1_fetch", ram_addr, 9'h005);
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h05A;
        tick();
        chk1 ("bb_g1_f_done", f_done, 1'b1);
        tick();
        chk1 ("bb_idle1_busy", busy, 1'b0);
        tick();
        d_req = 1'b0;
        chk9 ("bb_g2_data", ram_addr, 9'h05A);
        tick();
        chk1 ("bb_g2_d_done", d_done, 1'b1);
        chk32("bb_g2_rdata", rdata, 32'h12345678);
        tick();
        tick();
        chk9 ("bb_g3_fetch", ram_addr, 9'h005);
        tick();
        chk1 ("bb_g3_f_done", f_done, 1'b1);
        tick();
        tick();
        f_req = 1'b0;
        chk1 ("bb_g4_ram_read", ram_read, 1'b1);
        chk9 ("bb_g4_fetch", ram_addr, 9'h005);
        tick();
        chk1 ("bb_g4_f_done", f_done, 1'b1);
        chk32("bb_g4_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk1 ("bb_end_busy", busy, 1'b0);
        chk32("no_rd_wr_overlap", overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
